// File: rtl/aux_input_debouncer.sv
// Front-panel input conditioning: 2-flop synchronizers followed by stability-count
// debounce filters for the resume button and the slide-switch vector.
module aux_input_debouncer #(
  parameter int DebounceCnt = 500000,
  parameter int SwtBit      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resume_raw,
  input  logic [SwtBit-1:0] swt_raw,
  output logic              resume_level,
  output logic              resume_pulse,
  output logic [SwtBit-1:0] swt_out,
  output logic              swt_changed
);

  localparam int CntW = $clog2(DebounceCnt);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic              resume_s1;
  logic              resume_s2;
  logic [SwtBit-1:0] swt_s1;
  logic [SwtBit-1:0] swt_s2;

  logic [CntW-1:0]   btn_cnt;
  logic [CntW-1:0]   btn_cnt_nxt;
  logic              resume_level_nxt;
  logic              resume_pulse_nxt;

  logic [CntW-1:0]   swt_cnt;
  logic [CntW-1:0]   swt_cnt_nxt;
  logic [SwtBit-1:0] swt_cand;
  logic [SwtBit-1:0] swt_cand_nxt;
  logic [SwtBit-1:0] swt_out_nxt;
  logic              swt_changed_nxt;

  // Raw inputs are asynchronous; only the second flop stage feeds the filters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resume_s1 <= 1'b0;
      resume_s2 <= 1'b0;
      swt_s1    <= '0;
      swt_s2    <= '0;
    end else begin
      resume_s1 <= resume_raw;
      resume_s2 <= resume_s1;
      swt_s1    <= swt_raw;
      swt_s2    <= swt_s1;
    end
  end

  // Button: accept the new level after DebounceCnt consecutive mismatching samples.
  always_comb begin
    btn_cnt_nxt      = btn_cnt;
    resume_level_nxt = resume_level;
    resume_pulse_nxt = 1'b0;
    if (resume_s2 == resume_level) begin
      btn_cnt_nxt = '0;
    end else if (btn_cnt == CntLast) begin
      btn_cnt_nxt      = '0;
      resume_level_nxt = resume_s2;
      resume_pulse_nxt = resume_s2;
    end else begin
      btn_cnt_nxt = btn_cnt + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_cnt      <= '0;
      resume_level <= 1'b0;
      resume_pulse <= 1'b0;
    end else begin
      btn_cnt      <= btn_cnt_nxt;
      resume_level <= resume_level_nxt;
      resume_pulse <= resume_pulse_nxt;
    end
  end

  // Switches: the whole vector must hold one value; any movement restarts the count.
  always_comb begin
    swt_cnt_nxt     = swt_cnt;
    swt_cand_nxt    = swt_cand;
    swt_out_nxt     = swt_out;
    swt_changed_nxt = 1'b0;
    if (swt_s2 == swt_out) begin
      swt_cnt_nxt  = '0;
      swt_cand_nxt = swt_s2;
    end else if (swt_s2 != swt_cand) begin
      swt_cnt_nxt  = '0;
      swt_cand_nxt = swt_s2;
    end else if (swt_cnt == CntLast) begin
      swt_cnt_nxt     = '0;
      swt_out_nxt     = swt_s2;
      swt_changed_nxt = 1'b1;
    end else begin
      swt_cnt_nxt = swt_cnt + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swt_cnt     <= '0;
      swt_cand    <= '0;
      swt_out     <= '0;
      swt_changed <= 1'b0;
    end else begin
      swt_cnt     <= swt_cnt_nxt;
      swt_cand    <= swt_cand_nxt;
      swt_out     <= swt_out_nxt;
      swt_changed <= swt_changed_nxt;
    end
  end

endmodule

// File: tb/tb_aux_input_debouncer.sv
// Self-checking bench for aux_input_debouncer: directed scenarios plus random
// stimulus, compared every cycle against a sample-history reference model.
module tb_aux_input_debouncer;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         resume_raw = 1'b0;
  logic [W-1:0] swt_raw = '0;
  logic         resume_level;
  logic         resume_pulse;
  logic [W-1:0] swt_out;
  logic         swt_changed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aux_input_debouncer #(.DebounceCnt(N), .SwtBit(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .resume_raw   (resume_raw),
    .swt_raw      (swt_raw),
    .resume_level (resume_level),
    .resume_pulse (resume_pulse),
    .swt_out      (swt_out),
    .swt_changed  (swt_changed)
  );

  // Model: the filters see the raw value from two edges earlier. The button
  // accepts once the last N filtered samples all differ from its level; the
  // switches accept once the last N+1 filtered samples are identical and differ
  // from the current output. History before reset release reads as zero.
  bit           raw_b_q[$];
  logic [W-1:0] raw_s_q[$];
  bit           s2b_q[$];
  logic [W-1:0] s2s_q[$];
  bit           m_level;
  bit           m_pulse;
  bit           m_chg;
  logic [W-1:0] m_swt;

  function automatic void model_reset();
    raw_b_q.delete();
    raw_s_q.delete();
    s2b_q.delete();
    s2s_q.delete();
    m_level = 1'b0;
    m_pulse = 1'b0;
    m_chg   = 1'b0;
    m_swt   = '0;
  endfunction

  function automatic void model_edge(input bit rb, input logic [W-1:0] rs);
    bit           s2b;
    logic [W-1:0] s2s;
    bit           all_diff;
    bit           all_same;
    raw_b_q.push_back(rb);
    raw_s_q.push_back(rs);
    s2b = (raw_b_q.size() >= 3) ? raw_b_q[raw_b_q.size()-3] : 1'b0;
    s2s = (raw_s_q.size() >= 3) ? raw_s_q[raw_s_q.size()-3] : '0;
    if (raw_b_q.size() > 3) void'(raw_b_q.pop_front());
    if (raw_s_q.size() > 3) void'(raw_s_q.pop_front());
    s2b_q.push_back(s2b);
    s2s_q.push_back(s2s);
    if (s2b_q.size() > N + 1) void'(s2b_q.pop_front());
    if (s2s_q.size() > N + 1) void'(s2s_q.pop_front());
    m_pulse = 1'b0;
    m_chg   = 1'b0;
    all_diff = 1'b1;
    for (int i = 0; i < N; i++) begin
      int idx;
      bit v;
      idx = s2b_q.size() - 1 - i;
      v = (idx >= 0) ? s2b_q[idx] : 1'b0;
      if (v == m_level) all_diff = 1'b0;
    end
    if (all_diff) begin
      if (!m_level) m_pulse = 1'b1;
      m_level = s2b;
    end
    all_same = 1'b1;
    for (int i = 0; i <= N; i++) begin
      int idx;
      logic [W-1:0] v;
      idx = s2s_q.size() - 1 - i;
      v = (idx >= 0) ? s2s_q[idx] : '0;
      if (v != s2s) all_same = 1'b0;
    end
    if (all_same && (s2s != m_swt)) begin
      m_swt = s2s;
      m_chg = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rb, input logic [W-1:0] rs);
    resume_raw = rb;
    swt_raw    = rs;
    @(posedge clk);
    model_edge(rb, rs);
    #1;
    chk("model_level", {15'd0, resume_level}, {15'd0, m_level});
    chk("model_pulse", {15'd0, resume_pulse}, {15'd0, m_pulse});
    chk("model_swt",   swt_out, m_swt);
    chk("model_chg",   {15'd0, swt_changed}, {15'd0, m_chg});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, {15'd0, resume_level}, '0);
    chk({tag, "_pulse"}, {15'd0, resume_pulse}, '0);
    chk({tag, "_swt"},   swt_out, '0);
    chk({tag, "_chg"},   {15'd0, swt_changed}, '0);
  endtask

  initial begin
    int pulses;
    int chgs;
    bit rb;
    logic [W-1:0] rs;
    logic [W-1:0] pool [4];

    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Clean press: level after edge 6, pulse only in that cycle
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, '0);
      chk("t1_level", {15'd0, resume_level}, (i >= 6) ? 16'd1 : 16'd0);
      chk("t1_pulse", {15'd0, resume_pulse}, (i == 6) ? 16'd1 : 16'd0);
    end

    // Release: level drops after 6 edges, never pulses
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0);
      chk("t3_level", {15'd0, resume_level}, (i >= 6) ? 16'd0 : 16'd1);
      chk("t3_pulse", {15'd0, resume_pulse}, '0);
    end

    // Bounce: high 3, low 1, then high; accepted on edge 10, single pulse
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      step((i == 4) ? 1'b0 : 1'b1, '0);
      pulses += int'(resume_pulse);
      chk("t2_level", {15'd0, resume_level}, (i >= 10) ? 16'd1 : 16'd0);
    end
    chk("t2_pulses", 16'(pulses), 16'd1);
    for (int i = 0; i < 8; i++) step(1'b0, '0);

    // Vector flip to 0x00A5: valid after edge 7, one strobe
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 16'h00A5);
      chk("t4_swt", swt_out, (i >= 7) ? 16'h00A5 : 16'h0000);
      chk("t4_chg", {15'd0, swt_changed}, (i == 7) ? 16'd1 : 16'd0);
    end

    // 0x0001 then 0x0003 mid-count: 0x0001 must never reach the output
    chgs = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, (i <= 3) ? 16'h0001 : 16'h0003);
      chgs += int'(swt_changed);
      chk("t4_not_0001", {15'd0, (swt_out == 16'h0001)}, '0);
    end
    chk("t4_final", swt_out, 16'h0003);
    chk("t4_chgs", 16'(chgs), 16'd1);

    // Reset between edges while counting; all outputs clear at once
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0003);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h5A5A);
    chk("t5_pre_level", {15'd0, resume_level}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    @(posedge clk);
    #1;
    chk_all_zero("t5_held");
    model_reset();
    rst = 1'b0;
    chgs = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 16'hFFFF);
      chgs += int'(swt_changed);
      chk("t5_swt", swt_out, (i >= 7) ? 16'hFFFF : 16'h0000);
    end
    chk("t5_chgs", 16'(chgs), 16'd1);

    // Concurrent press and switch change: independent latencies
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 16'h1234);
      chk("t6_pulse", {15'd0, resume_pulse}, (i == 6) ? 16'd1 : 16'd0);
      chk("t6_chg",   {15'd0, swt_changed}, (i == 7) ? 16'd1 : 16'd0);
    end

    // Random walk with holds long enough to be accepted sometimes
    pool[0] = 16'h0000;
    pool[1] = 16'hBEEF;
    pool[2] = 16'h00F0;
    pool[3] = $urandom();
    rb = 1'b1;
    rs = 16'h1234;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      if ($urandom_range(0, 5) == 0) rs = pool[$urandom_range(0, 3)];
      step(rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aux_input_debouncer.md
Name:
aux_input_debouncer

Overview:
- Input-side counterpart of the board's display/output path.
- Conditions the raw, asynchronous front-panel inputs (resume push-button, 16 slide switches) before they reach the core-clock selector, display-data mux, debug address fields and the halt/resume controller.
- Each input goes through a 2-flop synchronizer and a stability-counter debounce filter.
- Emits clean levels plus single-cycle event pulses: resume rising edge, switch-vector update.

Parameters:
- DebounceCnt, 500000: cycles of continuous stability required before accepting a new value (10 ms at 50 MHz). Legal values are ≥2.
- SwtBit, 16: switch vector width.

Ports:
- clk  input  1  free-running board clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- resume_raw  input  1  raw push-button, asynchronous, bouncing.
- swt_raw  input  SwtBit  raw slide switches, asynchronous.
- resume_level  output  1  debounced button level.
- resume_pulse  output  1  one-cycle strobe on debounced 0→1 of the button.
- swt_out  output  SwtBit  debounced switch vector.
- swt_changed  output  1  one-cycle strobe whenever swt_out updates.

Behaviour:
- Reset (async, while rst=1):
  - Cleared: all synchronizer flops, counters and candidate registers.
  - Outputs: resume_level=0, resume_pulse=0, swt_out=0, swt_changed=0.
  - Release is sampled on the next rising edge.
- Synchronizers:
  - Two flops per bit: s1<=raw, s2<=s1.
  - Only s2 is used downstream. raw is never used combinationally.
- Counter width: clog2(DebounceCnt). There is a separate counter for the button and one shared counter for the whole switch vector.
- Button filter, each edge:
  - If s2==resume_level: cnt<=0.
  - Else if cnt==DebounceCnt-1: resume_level<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Latency: resume_raw sampled high at edge E (stable thereafter) → resume_level high after edge E+DebounceCnt+1.
  - A bounce back to the old level before acceptance clears cnt, and the count restarts from the next mismatch.
- resume_pulse:
  - Registered. It is 1 for exactly the cycle following the edge on which resume_level goes 0→1, otherwise 0.
  - A 1→0 transition produces no pulse.
- Switch filter (vector-wide, candidate register cand), each edge:
  - If s2v==swt_out: cnt<=0, cand<=s2v.
  - Else if s2v!=cand: cand<=s2v, cnt<=0 (the vector moved, so restart).
  - Else if cnt==DebounceCnt-1: swt_out<=s2v, cnt<=0, swt_changed<=1.
  - Else: cnt<=cnt+1.
- Switch filter rules:
  - swt_changed is 0 on every edge that does not update swt_out.
  - Latency: swt_raw sampled at edge E → swt_out valid after edge E+DebounceCnt+2.
  - swt_out always updates atomically as a whole vector. Intermediate combinations during multi-switch flips are never exposed unless held stable for DebounceCnt cycles.
  - The counter never wraps. It saturates by the acceptance rule above.
- Reset mid-count: all progress is discarded. Inputs already non-zero at reset release are accepted after normal latency, and swt_changed pulses once.
- Simultaneous button and switch events are independent. Both strobes may be high in the same cycle.

Test Plan:
(All with DebounceCnt=4.)
1. Clean press: resume_raw 0→1 before edge 1, held → resume_level=1 after edge 6; resume_pulse=1 for exactly the cycle after edge 6.
2. Bounce: resume_raw high for 3 cycles, low 1 cycle, then high → no acceptance until 4 consecutive mismatch counts following the last low; exactly one resume_pulse.
3. Release: resume_level=1, resume_raw→0 held → resume_level=0 after 6 edges; resume_pulse stays 0.
4. Vector flip: swt_raw 0x0000→0x00A5 before edge 1 → swt_out=0x00A5 after edge 7, swt_changed=1 for one cycle. Repeat with swt_raw stepping 0x0001→0x0003 mid-count → restart; only 0x0003 ever appears on swt_out.
5. Reset mid-operation: assert rst during counting, asynchronously between edges → all outputs 0 immediately. After release with swt_raw=0xFFFF held → swt_out=0xFFFF after 7 edges, with a single swt_changed pulse.
6. Concurrent events: press and switch change in the same cycle → resume_pulse and swt_changed assert per their independent latencies (cycles 7 and 8 respectively), with no interference.
